// File: rtl/sensor_encoder_sync.sv
`default_nettype none
// ============================================================================
// sensor_encoder_sync: synchronizes and debounces a sensor bus, encodes one-hot
// Revision: 1.0
// ============================================================================
module sensor_encoder_sync #(
  parameter  int N_IN          = 7,
  parameter  int STABLE_CYCLES = 4,
  localparam int CODE_W        = $clog2(N_IN + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_IN-1:0]   in_vec,
  input  logic              enable,
  output logic [CODE_W-1:0] code,
  output logic              multi_err,
  output logic              code_valid,
  output logic              change_pulse
);

  localparam int               CNT_W       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX   = CNT_W'(STABLE_CYCLES);
  localparam logic [1:0]       C_ST_IDLE   = 2'd0;
  localparam logic [1:0]       C_ST_LOCKED = 2'd1;
  localparam logic [1:0]       C_ST_FAULT  = 2'd2;

  logic [N_IN-1:0]   sync1_q, sync1_d;
  logic [N_IN-1:0]   sync2_q, sync2_d;
  logic [N_IN-1:0]   prev_q, prev_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic              code_valid_q, code_valid_d;
  logic              multi_err_q, multi_err_d;
  logic              change_pulse_q, change_pulse_d;

  logic              cls_any;
  logic              cls_multi;
  logic [CODE_W-1:0] cls_idx;
  logic              accept;

  // Synchronizer chain is pure wiring; prev holds the previous synchronized sample.
  always_comb begin
    sync1_d = in_vec;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Scan high to low so the lowest set bit wins the index.
  always_comb begin
    cls_any   = 1'b0;
    cls_multi = 1'b0;
    cls_idx   = '0;
    for (int i = N_IN - 1; i >= 0; i--) begin
      if (sync2_q[i]) begin
        cls_multi = cls_multi | cls_any;
        cls_any   = 1'b1;
        cls_idx   = CODE_W'(i);
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!enable || (sync2_q != prev_q)) begin
      cnt_d = '0;
    end else if (cnt_q != C_CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Acceptance repeats while saturated; an unchanged result raises no pulse.
  assign accept = enable && (cnt_d == C_CNT_MAX);

  always_comb begin
    state_d        = state_q;
    code_d         = code_q;
    code_valid_d   = code_valid_q;
    multi_err_d    = multi_err_q;
    change_pulse_d = 1'b0;
    if (accept) begin
      if (cls_multi) begin
        state_d      = C_ST_FAULT;
        code_d       = '0;
        code_valid_d = 1'b0;
        multi_err_d  = 1'b1;
      end else if (cls_any) begin
        state_d      = C_ST_LOCKED;
        code_d       = cls_idx + CODE_W'(1);
        code_valid_d = 1'b1;
        multi_err_d  = 1'b0;
      end else begin
        state_d      = C_ST_IDLE;
        code_d       = '0;
        code_valid_d = 1'b0;
        multi_err_d  = 1'b0;
      end
      change_pulse_d = (state_d != state_q) || (code_d != code_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      prev_q         <= '0;
      cnt_q          <= '0;
      state_q        <= C_ST_IDLE;
      code_q         <= '0;
      code_valid_q   <= 1'b0;
      multi_err_q    <= 1'b0;
      change_pulse_q <= 1'b0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      prev_q         <= prev_d;
      cnt_q          <= cnt_d;
      state_q        <= state_d;
      code_q         <= code_d;
      code_valid_q   <= code_valid_d;
      multi_err_q    <= multi_err_d;
      change_pulse_q <= change_pulse_d;
    end
  end

  assign code         = code_q;
  assign code_valid   = code_valid_q;
  assign multi_err    = multi_err_q;
  assign change_pulse = change_pulse_q;

endmodule
`default_nettype wire

// File: tb/tb_sensor_encoder_sync.sv
`default_nettype none
// Self-checking bench for sensor_encoder_sync: directed scenarios plus random
// stimulus compared every cycle against a windowed-history reference model.
module tb_sensor_encoder_sync;

  localparam int N = 7;
  localparam int S = 4;
  localparam int D = S + 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0;
  logic [N-1:0] in_vec = '0;
  logic [2:0]   code;
  logic         multi_err, code_valid, change_pulse;

  logic [15:0]  in16 = '0;
  logic [4:0]   code16;
  logic         me16, cv16, cp16;

  always #5 clk = ~clk;

  sensor_encoder_sync #(.N_IN(N), .STABLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .in_vec(in_vec), .enable(enable),
    .code(code), .multi_err(multi_err), .code_valid(code_valid),
    .change_pulse(change_pulse)
  );

  sensor_encoder_sync #(.N_IN(16), .STABLE_CYCLES(S)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_vec(in16), .enable(enable),
    .code(code16), .multi_err(me16), .code_valid(cv16),
    .change_pulse(cp16)
  );

  int n_checks = 0;
  int n_errors = 0;
  int pcount   = 0;

  // hx[k]/he[k]: in_vec and enable as sampled k edges ago.
  logic [N-1:0] hx [D];
  logic         he [D];
  logic [2:0]   m_code;
  logic         m_valid, m_err, m_pulse;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // A value is accepted once the enable was high for the last S edges and the
  // sample that reached the comparison stage matched for S consecutive steps.
  task automatic model_step(input logic [N-1:0] x, input logic en, input logic rn);
    logic         ok;
    logic [N-1:0] v;
    logic [2:0]   nc;
    logic         nv, ne;
    if (!rn) begin
      for (int k = 0; k < D; k++) begin
        hx[k] = '0;
        he[k] = 1'b0;
      end
      m_code = '0; m_valid = 1'b0; m_err = 1'b0; m_pulse = 1'b0;
    end else begin
      for (int k = D - 1; k > 0; k--) begin
        hx[k] = hx[k-1];
        he[k] = he[k-1];
      end
      hx[0] = x;
      he[0] = en;
      ok = 1'b1;
      for (int k = 0; k < S; k++) if (!he[k]) ok = 1'b0;
      for (int k = 3; k <= S + 2; k++) if (hx[k] != hx[2]) ok = 1'b0;
      m_pulse = 1'b0;
      if (ok) begin
        v  = hx[2];
        nc = '0; nv = 1'b0; ne = 1'b0;
        if ($countones(v) == 1) begin
          for (int b = 0; b < N; b++) if (v[b]) nc = 3'(b + 1);
          nv = 1'b1;
        end else if ($countones(v) > 1) begin
          ne = 1'b1;
        end
        m_pulse = ({nc, nv, ne} != {m_code, m_valid, m_err});
        m_code  = nc;
        m_valid = nv;
        m_err   = ne;
      end
    end
  endtask

  task automatic tick();
    logic [N-1:0] x;
    logic         en, rn;
    x  = in_vec;
    en = enable;
    rn = rst_n;
    @(posedge clk);
    #1;
    model_step(x, en, rn);
    pcount += int'(change_pulse);
    check_val("m_code", 32'(code), 32'(m_code));
    check_val("m_valid", 32'(code_valid), 32'(m_valid));
    check_val("m_err", 32'(multi_err), 32'(m_err));
    check_val("m_pulse", 32'(change_pulse), 32'(m_pulse));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int hold;
    // Reset state
    rst_n = 1'b0;
    ticks(3);
    check_val("rst_code", 32'(code), 32'd0);
    check_val("rst_valid", 32'(code_valid), 32'd0);
    check_val("rst_err", 32'(multi_err), 32'd0);
    check_val("rst_pulse", 32'(change_pulse), 32'd0);

    // NONE as first accepted value gives no pulse
    rst_n = 1'b1; enable = 1'b1; pcount = 0;
    ticks(10);
    check_val("none_after_rst_pulses", 32'(pcount), 32'd0);

    // Latency: held from edge 0, outputs move on edge 6 only
    in_vec = 7'b0000100;
    for (int e = 0; e <= 6; e++) begin
      tick();
      if (e < 6) begin
        check_val("lat_code_hold", 32'(code), 32'd0);
        check_val("lat_pulse_hold", 32'(change_pulse), 32'd0);
      end else begin
        check_val("lat_code", 32'(code), 32'd3);
        check_val("lat_valid", 32'(code_valid), 32'd1);
        check_val("lat_pulse", 32'(change_pulse), 32'd1);
      end
    end
    tick();
    check_val("lat_pulse_once", 32'(change_pulse), 32'd0);

    // LOCKED -> FAULT -> IDLE, one pulse each
    in_vec = 7'b0100100; pcount = 0;
    ticks(12);
    check_val("fault_err", 32'(multi_err), 32'd1);
    check_val("fault_code", 32'(code), 32'd0);
    check_val("fault_valid", 32'(code_valid), 32'd0);
    check_val("fault_pulses", 32'(pcount), 32'd1);
    in_vec = '0; pcount = 0;
    ticks(12);
    check_val("idle_err", 32'(multi_err), 32'd0);
    check_val("idle_pulses", 32'(pcount), 32'd1);

    // Glitch of 3 cycles is rejected
    in_vec = 7'b0000001;
    ticks(10);
    check_val("pre_glitch_code", 32'(code), 32'd1);
    in_vec = 7'b1000000; pcount = 0;
    ticks(3);
    in_vec = 7'b0000001;
    ticks(10);
    check_val("glitch_code", 32'(code), 32'd1);
    check_val("glitch_pulses", 32'(pcount), 32'd0);

    // Enable low freezes; after rising, already-synced input lands on 4th edge
    enable = 1'b0; in_vec = 7'b1000000; pcount = 0;
    ticks(10);
    check_val("frozen_code", 32'(code), 32'd1);
    check_val("frozen_pulses", 32'(pcount), 32'd0);
    enable = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      if (e == 3) check_val("en_code_early", 32'(code), 32'd1);
      if (e == 4) begin
        check_val("en_code", 32'(code), 32'd7);
        check_val("en_pulse", 32'(change_pulse), 32'd1);
      end
    end

    // Reset mid-qualification discards the partial count
    in_vec = 7'b0000010;
    ticks(2);
    rst_n = 1'b0;
    tick();
    check_val("midrst_code", 32'(code), 32'd0);
    check_val("midrst_valid", 32'(code_valid), 32'd0);
    check_val("midrst_pulse", 32'(change_pulse), 32'd0);
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e < 7) check_val("relq_hold", 32'(code), 32'd0);
      else check_val("relq_code", 32'(code), 32'd2);
    end

    // Randomized traffic against the model
    for (int c = 0; c < 700; c += hold) begin
      hold = int'($urandom_range(1, 8));
      case ($urandom_range(0, 3))
        0: in_vec = '0;
        1: in_vec = N'(1) << $urandom_range(0, N - 1);
        2: in_vec = N'($urandom);
        default: ;
      endcase
      enable = ($urandom_range(0, 9) != 0);
      rst_n  = ($urandom_range(0, 49) != 0);
      ticks(hold);
    end
    rst_n = 1'b1; enable = 1'b1;
    ticks(10);

    // Wide build
    in16 = 16'h8000;
    ticks(10);
    check_val("w16_code", 32'(code16), 32'd16);
    check_val("w16_valid", 32'(cv16), 32'd1);
    check_val("w16_err", 32'(me16), 32'd0);
    in16 = 16'h0001;
    ticks(10);
    check_val("w16_code1", 32'(code16), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
